// File: rtl/dac_spi_tx_pkg.sv
// Shared types and frame geometry for the DAC SPI transmitter.
package dac_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CMD_W      = 4;
    localparam int PAD_W      = 4;
    localparam int DATA_W     = FRAME_BITS - CMD_W - PAD_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [CMD_W-1:0]  cmd,
        input logic [DATA_W-1:0] code
    );
        return {cmd, code, {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sweep-counter request side plus DAC pins of the SPI transmitter.
interface dac_spi_tx_if;
    import dac_spi_pkg::*;

    logic              spi_start;
    logic [DATA_W-1:0] voltage;
    logic              cs_n;
    logic              sclk;
    logic              mosi;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output spi_start, voltage,
        input  cs_n, sclk, mosi, busy, done, overrun
    );

    modport slave (
        input  spi_start, voltage,
        output cs_n, sclk, mosi, busy, done, overrun
    );

endinterface

// File: rtl/dac_spi_tx_tick_gen.sv
// Divide-by-DIV prescaler; tick marks the last clk of each sclk half-period.
module spi_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (clr || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Mode-1 SPI frame sender for the sweep DAC with a one-deep request buffer.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int               CLK_DIV    = 2,
    parameter logic [CMD_W-1:0] CMD_CODE   = 4'b0000,
    parameter int               GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    dac_spi_tx_if.slave bus
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d, frame;
    logic [3:0]            bit_q, bit_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_W-1:0]     pend_q, pend_d, load_val;
    logic                  pend_vld_q, pend_vld_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d;
    logic                  done_q, done_d, ovr_q, ovr_d;
    logic                  cs_n_q, busy_q;
    logic                  load, tick, tick_clr, gap_end;

    assign gap_end  = (gap_q == GW'(GAP_CYCLES - 1));
    assign tick_clr = load || (state_q == ST_IDLE) || (state_q == ST_GAP);

    spi_tick_gen #(.DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        load       = 1'b0;
        load_val   = bus.voltage;
        frame      = '0;

        if (bus.spi_start && state_q != ST_IDLE) begin
            pend_d     = bus.voltage;
            pend_vld_d = 1'b1;
            if (pend_vld_q)
                ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    load     = 1'b1;
                    load_val = pend_q;
                end else if (bus.spi_start) begin
                    load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                        sreg_d = {sreg_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d = sreg_q[FRAME_BITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    done_d  = 1'b1;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                // Hand the queued request straight to SETUP so frames are spaced by exactly GAP_CYCLES;
                // a strobe landing on this cycle is the newest value and wins over the buffered one.
                if (gap_end) begin
                    if (bus.spi_start) begin
                        load = 1'b1;
                    end else if (pend_vld_q) begin
                        load     = 1'b1;
                        load_val = pend_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            frame      = build_frame(CMD_CODE, load_val);
            state_d    = ST_SETUP;
            sreg_d     = frame;
            mosi_d     = frame[FRAME_BITS-1];
            sclk_d     = 1'b0;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            cs_n_q     <= !(state_d == ST_SETUP || state_d == ST_SHIFT || state_d == ST_HOLD);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign bus.cs_n    = cs_n_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = ovr_q;

endmodule
